cv32e40p_sleep_ctrl: RTL and testbench



---
 rtl/cv32e40p_sleep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cv32e40p_sleep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep controller: gates the core clock after a programmable idle delay and wakes on masked sources.
// Optional 32-bit sleep-cycle counter is built when CV32E40P_SLEEP_CNT_EN is defined.

module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic rst_n,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_latched;

  // Latch is transparent while the clock is low so the enable is stable across the high phase;
  // reset forces the gate closed immediately.
  always_latch begin
    if (!rst_n) begin
      en_latched <= 1'b0;
    end else if (!clk_i) begin
      en_latched <= en_i | scan_cg_en_i;
    end
  end

  assign clk_o = clk_i & en_latched;

endmodule

module cv32e40p_sleep_ctrl #(
  parameter int unsigned N_BUSY   = 4,
  parameter int unsigned N_WAKE   = 2,
  parameter int unsigned IDLE_DLY = 2
) (
  input  logic              clk_ungated_i,
  input  logic              rst_n,
  input  logic              scan_cg_en_i,
  output logic              clk_gated_o,
  input  logic              fetch_enable_i,
  output logic              fetch_enable_o,
  input  logic [N_BUSY-1:0] busy_i,
  input  logic              sleep_allow_i,
  input  logic [N_WAKE-1:0] wake_i,
  input  logic [N_WAKE-1:0] wake_mask_i,
  output logic              core_sleep_o,
  output logic [31:0]       sleep_cycles_o
);

  localparam int unsigned CNT_W = (IDLE_DLY == 0) ? 1 : $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (IDLE_DLY == 0) ? '0 : CNT_W'(IDLE_DLY - 1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    IDLE  = 2'd2,
    SLEEP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_en_q, fetch_en_d;
  logic             idle;
  logic             wake_any;
  logic             sleep_ok;
  logic             clock_en;
  logic             core_sleep;

  assign idle     = ~|busy_i;
  assign wake_any = |(wake_i & wake_mask_i);
  assign sleep_ok = idle & sleep_allow_i & ~wake_any;

  assign fetch_en_d = fetch_en_q | fetch_enable_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clock_en   = 1'b0;
    core_sleep = 1'b0;
    case (state_q)
      OFF: begin
        // Leave OFF in the same cycle the enable arrives so the clock runs from the next cycle.
        if (fetch_en_d) begin
          state_d = RUN;
        end
      end
      RUN: begin
        clock_en = 1'b1;
        if (sleep_ok) begin
          if (IDLE_DLY == 0) begin
            state_d = SLEEP;
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      IDLE: begin
        clock_en = 1'b1;
        if (!sleep_ok) begin
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = SLEEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SLEEP: begin
        // Wake opens the gate combinationally so the first edge lands at the end of the wake cycle.
        clock_en   = wake_any;
        core_sleep = ~wake_any;
        if (wake_any) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      fetch_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_en_q <= fetch_en_d;
    end
  end

  assign fetch_enable_o = fetch_en_q;
  assign core_sleep_o   = core_sleep;

  cv32e40p_clock_gate u_clock_gate (
    .clk_i        (clk_ungated_i),
    .rst_n        (rst_n),
    .en_i         (clock_en),
    .scan_cg_en_i (scan_cg_en_i),
    .clk_o        (clk_gated_o)
  );

`ifdef CV32E40P_SLEEP_CNT_EN
  logic [31:0] sleep_cnt_q, sleep_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (state_q == SLEEP) begin
      sleep_cnt_d = sat_inc(sleep_cnt_q);
    end
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cnt_q <= '0;
    end else begin
      sleep_cnt_q <= sleep_cnt_d;
    end
  end

  assign sleep_cycles_o = sleep_cnt_q;
`else
  assign sleep_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Directed bench for cv32e40p_sleep_ctrl: expectations are queued when stimulus is applied and checked at sample points.
module tb_cv32e40p_sleep_ctrl;

  localparam int S_FE    = 0;
  localparam int S_SLP   = 1;
  localparam int S_CNT   = 2;
  localparam int S_GEDGE = 3;
  localparam int S_GLVL  = 4;

  logic        clk;
  logic        rst_n;
  logic        scan;
  logic        clk_gated;
  logic        fe;
  logic        fe_o;
  logic [3:0]  busy;
  logic        allow;
  logic [1:0]  wake;
  logic [1:0]  mask;
  logic        core_sleep;
  logic [31:0] sleep_cycles;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   gcnt    = 0;
  int   gmark   = 0;
  int   slp     = 0;

  cv32e40p_sleep_ctrl #(
    .N_BUSY   (4),
    .N_WAKE   (2),
    .IDLE_DLY (2)
  ) dut (
    .clk_ungated_i  (clk),
    .rst_n          (rst_n),
    .scan_cg_en_i   (scan),
    .clk_gated_o    (clk_gated),
    .fetch_enable_i (fe),
    .fetch_enable_o (fe_o),
    .busy_i         (busy),
    .sleep_allow_i  (allow),
    .wake_i         (wake),
    .wake_mask_i    (mask),
    .core_sleep_o   (core_sleep),
    .sleep_cycles_o (sleep_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk_gated) gcnt <= gcnt + 1;

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_FE:    return {31'd0, fe_o};
      S_SLP:   return {31'd0, core_sleep};
      S_CNT:   return sleep_cycles;
      S_GEDGE: return 32'(gcnt - gmark);
      default: return {31'd0, clk_gated};
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef CV32E40P_SLEEP_CNT_EN
    return 32'(slp);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps taken while the DUT is expected to be in SLEEP.
  task automatic sstep(input int n);
    step(n);
    slp = slp + n;
  endtask

  task automatic mark();
    gmark = gcnt;
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_tests++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    scan  = 1'b0;
    fe    = 1'b0;
    busy  = 4'b0000;
    allow = 1'b0;
    wake  = 2'b00;
    mask  = 2'b00;

    step(2);
    push("rst_fe", S_FE, 0);
    push("rst_sleep", S_SLP, 0);
    push("rst_cnt", S_CNT, 0);
    push("rst_gclk", S_GLVL, 0);
    drain();

    rst_n = 1'b1;
    mark();
    step(3);
    push("off_no_clk", S_GEDGE, 0);
    push("off_fe", S_FE, 0);
    drain();

    fe   = 1'b1;
    busy = 4'b0001;
    step(1);
    fe = 1'b0;
    push("fe_set", S_FE, 1);
    drain();
    mark();
    step(4);
    push("run_clk", S_GEDGE, 4);
    push("fe_sticky", S_FE, 1);
    push("run_awake", S_SLP, 0);
    drain();

    // Idle conditions first true in cycle c0; sleep expected at c0+3.
    mask  = 2'b01;
    busy  = 4'b0000;
    allow = 1'b1;
    mark();
    step(1);
    push("idle1", S_SLP, 0);
    drain();
    step(1);
    push("idle2", S_SLP, 0);
    drain();
    step(1);
    push("slp_enter", S_SLP, 1);
    push("slp_enter_clk", S_GEDGE, 3);
    push("slp_cnt0", S_CNT, exp_cnt());
    drain();
    mark();

    wake = 2'b10;
    sstep(5);
    push("masked_wake", S_SLP, 1);
    push("masked_gate", S_GEDGE, 0);
    drain();
    busy = 4'b0100;
    sstep(1);
    push("busy_no_wake", S_SLP, 1);
    drain();
    busy = 4'b0000;
    sstep(14);
    push("slp20_cnt", S_CNT, exp_cnt());
    push("slp_gate_closed", S_GEDGE, 0);
    drain();

    wake  = 2'b01;
    allow = 1'b0;
    push("wake_sleep_drop", S_SLP, 0);
    drain();
    mark();
    sstep(1);
    push("wake_edge", S_GEDGE, 1);
    drain();
    wake = 2'b00;
    mark();
    step(3);
    push("run_after_wake", S_GEDGE, 3);
    push("awake", S_SLP, 0);
    push("cnt_hold", S_CNT, exp_cnt());
    drain();

    // Abort in the second IDLE cycle, then full re-entry.
    allow = 1'b1;
    mark();
    step(2);
    busy = 4'b0100;
    push("idle_sleep", S_SLP, 0);
    drain();
    step(1);
    busy = 4'b0000;
    push("abort_awake", S_SLP, 0);
    push("abort_clk", S_GEDGE, 3);
    drain();
    step(2);
    push("reentry_wait", S_SLP, 0);
    drain();
    step(1);
    push("reentry_sleep", S_SLP, 1);
    drain();

    scan = 1'b1;
    mark();
    sstep(2);
    push("scan_clk", S_GEDGE, 2);
    push("scan_sleep", S_SLP, 1);
    drain();
    scan = 1'b0;
    push("pre_rst_cnt", S_CNT, exp_cnt());
    drain();

    rst_n = 1'b0;
    slp   = 0;
    push("arst_sleep", S_SLP, 0);
    push("arst_fe", S_FE, 0);
    push("arst_cnt", S_CNT, 0);
    push("arst_gclk", S_GLVL, 0);
    drain();

    step(1);
    rst_n = 1'b1;
    mark();
    step(3);
    push("post_rst_off", S_GEDGE, 0);
    push("post_rst_fe", S_FE, 0);
    drain();

    fe    = 1'b1;
    busy  = 4'b0001;
    allow = 1'b0;
    step(1);
    fe = 1'b0;
    push("restart_fe", S_FE, 1);
    drain();
    mark();
    step(2);
    push("restart_clk", S_GEDGE, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
